// File: rtl/mc_alu.sv
// mc_alu: single-cycle ALU with an optional iterative shift-add multiplier.
// Single-cycle ops complete in IDLE -> DONE. A multiply walks IDLE -> MUL
// (WIDTH steps) -> DONE. result/zero/overflow/illegal are held between
// done pulses.
module mc_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ALUctr,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    // Main-control op classes
    localparam logic [1:0] CTR_ADD = 2'b00;
    localparam logic [1:0] CTR_SUB = 2'b01;
    localparam logic [1:0] CTR_RT  = 2'b10;
    localparam logic [1:0] CTR_OR  = 2'b11;

    // R-type function codes
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_MUL = 6'b011000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    // Multiplier datapath state
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Architectural output registers
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    // Single-cycle ALU signals
    logic [WIDTH-1:0] sum, diff;
    logic             add_ov, sub_ov;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;
    logic             alu_ill;
    logic             is_mul;

    logic             accept;
    logic             mul_last;
    logic [WIDTH-1:0] step_acc;

    // Shared adder/subtractor and signed-overflow detection (wraps mod 2^WIDTH)
    assign sum    = a + b;
    assign diff   = a - b;
    assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign shamt  = b[SHW-1:0];

    assign accept   = (state_q == S_IDLE) && start;
    assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(1));

    // Opcode decode and single-cycle result selection
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        alu_res = '0;
        alu_ov  = 1'b0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        case (ALUctr)
            CTR_ADD: begin
                alu_res = sum;
                alu_ov  = add_ov;
            end
            CTR_SUB: begin
                alu_res = diff;
                alu_ov  = sub_ov;
            end
            CTR_OR: begin
                alu_res = a | b;
            end
            CTR_RT: begin
                case (func)
                    F_ADD: begin
                        alu_res = sum;
                        alu_ov  = add_ov;
                    end
                    F_SUB: begin
                        alu_res = diff;
                        alu_ov  = sub_ov;
                    end
                    F_AND: alu_res = a & b;
                    F_OR:  alu_res = a | b;
                    F_XOR: alu_res = a ^ b;
                    F_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    F_SLL: alu_res = a << shamt;
                    F_SRL: alu_res = a >> shamt;
                    F_MUL: begin
                        // Without the multiplier a mul opcode is simply undefined.
                        if (MUL_EN) begin
                            is_mul = 1'b1;
                        end else begin
                            alu_ill = 1'b1;
                        end
                    end
                    default: alu_ill = 1'b1;
                endcase
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Multiplier datapath next state: load on accept, iterate in MUL
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept && is_mul) begin
            // Operands are captured here so later input changes cannot disturb the product.
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (state_q == S_MUL) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    // Output register next state: update only when an operation completes
    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        if (accept && !is_mul) begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_ov;
            illegal_d  = alu_ill;
        end else if (mul_last) begin
            // Truncated product never reports overflow.
            result_d   = step_acc;
            zero_d     = (step_acc == '0);
            overflow_d = 1'b0;
            illegal_d  = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy while iterating, done for the single DONE cycle
    always_comb begin
        busy = (state_q == S_MUL);
        done = (state_q == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        // NOTE: the accumulator, counter and operand registers are reset along
        // with the outputs so an aborted multiply leaves no stale partial product.
        if (rst) begin
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_alu.sv
// Testbench for mc_alu: randomized and directed ops, scoreboard-checked
// against a plain-arithmetic reference model.
module tb_mc_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    ALUctr;
    logic [5:0]    func;
    logic [W-1:0]  a, b;
    logic [W-1:0]  result;
    logic          zero, overflow, illegal, busy, done;

    // Second instance with the multiplier disabled
    logic          start_n;
    logic [1:0]    ctr_n;
    logic [5:0]    func_n;
    logic [W-1:0]  a_n, b_n;
    logic [W-1:0]  result_n;
    logic          zero_n, overflow_n, illegal_n, busy_n, done_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         ill;
        bit           mul;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];

    mc_alu #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ALUctr(ALUctr), .func(func),
        .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
        .illegal(illegal), .busy(busy), .done(done)
    );

    mc_alu #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nomul (
        .clk(clk), .rst(rst), .start(start_n), .ALUctr(ctr_n), .func(func_n),
        .a(a_n), .b(b_n), .result(result_n), .zero(zero_n), .overflow(overflow_n),
        .illegal(illegal_n), .busy(busy_n), .done(done_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: evaluates the op with wide integer arithmetic
    function automatic exp_t model(input logic [1:0] ctr, input logic [5:0] fn,
                                   input logic [W-1:0] x, input logic [W-1:0] y,
                                   input bit mul_en);
        exp_t        e;
        longint      sx, sy, r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        e.res = '0; e.ov = 1'b0; e.ill = 1'b0; e.mul = 1'b0; e.done_cyc = 0;
        r = 0;
        case (ctr)
            2'b00: begin r = sx + sy; e.res = r[W-1:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            2'b01: begin r = sx - sy; e.res = r[W-1:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            2'b11: e.res = x | y;
            default: begin
                case (fn)
                    6'b100000: begin r = sx + sy; e.res = r[W-1:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
                    6'b100010: begin r = sx - sy; e.res = r[W-1:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
                    6'b100100: e.res = x & y;
                    6'b100101: e.res = x | y;
                    6'b100110: e.res = x ^ y;
                    6'b101010: e.res = (sx < sy) ? 32'd1 : 32'd0;
                    6'b000000: e.res = x << (y % W);
                    6'b000010: e.res = x >> (y % W);
                    6'b011000: begin
                        if (mul_en) begin
                            p = {32'b0, x} * {32'b0, y};
                            e.res = p[W-1:0];
                            e.mul = 1'b1;
                        end else begin
                            e.ill = 1'b1;
                        end
                    end
                    default: e.ill = 1'b1;
                endcase
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",     result,   e.res);
                check("zero",       zero,     e.z);
                check("overflow",   overflow, e.ov);
                check("illegal",    illegal,  e.ill);
                check("done_cycle", cyc,      e.done_cyc);
            end
        end
    end

    // Issue one op at a negedge with the DUT idle; return once it is idle again
    task automatic run_op(input logic [1:0] ctr, input logic [5:0] fn,
                          input logic [W-1:0] x, input logic [W-1:0] y, input bit perturb);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        e = model(ctr, fn, x, y, 1'b1);
        ALUctr = ctr; func = fn; a = x; b = y; start = 1'b1;
        e.done_cyc = cyc + 1 + (e.mul ? W : 0);
        sb.push_back(e);
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (perturb) begin
                a = $urandom; b = $urandom; ALUctr = 2'($urandom); func = 6'($urandom);
                start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("done_seen", seen, 1'b1);
        check("busy_cycles", busy_cnt, e.mul ? W : 0);
        // start raised while in DONE must be ignored
        start = 1'b1; a = $urandom; b = $urandom; ALUctr = 2'($urandom); func = 6'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] legal_funcs[9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                   6'b101010, 6'b000000, 6'b000010, 6'b011000};

    initial begin
        rst = 1'b1; start = 1'b0; ALUctr = 2'b00; func = 6'b0; a = '0; b = '0;
        start_n = 1'b0; ctr_n = 2'b00; func_n = 6'b0; a_n = '0; b_n = '0;
        repeat (3) @(negedge clk);
        check("rst_result",   result,   32'h0);
        check("rst_zero",     zero,     1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_illegal",  illegal,  1'b0);
        check("rst_busy",     busy,     1'b0);
        check("rst_done",     done,     1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        run_op(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(2'b01, 6'b000000, 32'd5, 32'd5, 1'b0);
        run_op(2'b11, 6'b000000, 32'hF0, 32'h0F, 1'b0);
        run_op(2'b10, 6'b011000, 32'd1234, 32'd5678, 1'b1);
        run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(2'b10, 6'b000010, 32'h8000_0000, 32'd31, 1'b0);
        run_op(2'b10, 6'b111111, 32'h1234_5678, 32'd9, 1'b0);
        run_op(2'b10, 6'b000000, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b0);
        run_op(2'b10, 6'b000010, 32'hDEAD_BEEF, 32'h0000_0020, 1'b0);
        run_op(2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(2'b01, 6'b000000, 32'h8000_0000, 32'd1, 1'b0);
        run_op(2'b10, 6'b100010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 6'b011000, 32'h0, 32'h1234, 1'b1);

        // Randomized ops
        for (int n = 0; n < 200; n++) begin
            logic [1:0] c;
            logic [5:0] f;
            c = 2'($urandom);
            if ($urandom_range(0, 5) == 0) f = 6'($urandom);
            else f = legal_funcs[$urandom_range(0, 8)];
            run_op(c, f, pick_operand(), pick_operand(), 1'($urandom));
        end

        // Abort a multiply with reset; reset also wins over start
        run_op(2'b00, 6'b0, 32'd7, 32'd8, 1'b0);
        ALUctr = 2'b10; func = 6'b011000; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_mid_mul", busy, 1'b1);
        rst = 1'b1;
        ALUctr = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
        @(negedge clk);
        check("abort_result",   result,   32'h0);
        check("abort_zero",     zero,     1'b0);
        check("abort_overflow", overflow, 1'b0);
        check("abort_illegal",  illegal,  1'b0);
        check("abort_busy",     busy,     1'b0);
        check("abort_done",     done,     1'b0);
        @(negedge clk);
        check("rst_over_start_done", done, 1'b0);
        check("rst_over_start_busy", busy, 1'b0);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);
        check("post_abort_busy", busy, 1'b0);
        run_op(2'b00, 6'b0, 32'd2, 32'd3, 1'b0);

        // Multiplier disabled: mul decodes as illegal, single-cycle
        ctr_n = 2'b10; func_n = 6'b011000; a_n = 32'd1234; b_n = 32'd5678; start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        check("nomul_done",    done_n,    1'b1);
        check("nomul_illegal", illegal_n, 1'b1);
        check("nomul_result",  result_n,  32'h0);
        check("nomul_zero",    zero_n,    1'b1);
        check("nomul_busy",    busy_n,    1'b0);
        @(negedge clk);
        check("nomul_done_clr", done_n, 1'b0);
        check("nomul_busy2",    busy_n, 1'b0);
        ctr_n = 2'b00; a_n = 32'd40; b_n = 32'd2; start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        check("nomul_add_done",    done_n,    1'b1);
        check("nomul_add_result",  result_n,  32'd42);
        check("nomul_add_illegal", illegal_n, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
